// File: rtl/button_pkg.sv
// Shared button-handling types and 50 MHz default timing constants.
package button_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        GAP,
        PRESS2,
        LONG
    } press_state_t;

    localparam int unsigned DEF_LONG_PRESS_TIME = 50_000_000;
    localparam int unsigned DEF_DOUBLE_GAP_TIME = 12_500_000;

endpackage

// File: rtl/press_classifier.sv
// Turns a debounced button level into click / double-click / long-press pulses.
// Every output is a register updated by the single FSM process.
module press_classifier
    import button_pkg::*;
#(
    parameter int unsigned LONG_PRESS_TIME = DEF_LONG_PRESS_TIME,
    parameter int unsigned DOUBLE_GAP_TIME = DEF_DOUBLE_GAP_TIME
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_level,
    output logic click_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic long_held,
    output logic busy
);

    localparam int unsigned MAX_TIME = (LONG_PRESS_TIME > DOUBLE_GAP_TIME) ?
                                       LONG_PRESS_TIME : DOUBLE_GAP_TIME;
    localparam int unsigned CNT_W    = $clog2(MAX_TIME + 1);

    // The threshold fires on the sample that would bring cnt up to the limit.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_TIME - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP_TIME - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_TIME);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    press_state_t     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_prev;

    logic             w_rise;
    logic             w_fall;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_rise    = btn_level & ~r_prev;
    assign w_fall    = ~btn_level & r_prev;
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_prev       <= 1'b0;
            click_pulse  <= 1'b0;
            double_pulse <= 1'b0;
            long_pulse   <= 1'b0;
            long_held    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            r_prev       <= btn_level;
            click_pulse  <= 1'b0;
            double_pulse <= 1'b0;
            long_pulse   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state <= PRESS1;
                        r_cnt   <= CNT_ONE;
                        busy    <= 1'b1;
                    end
                end
                PRESS1: begin
                    if (w_fall) begin
                        r_state <= GAP;
                        r_cnt   <= CNT_ONE;
                    end else if (r_cnt >= LONG_LAST) begin
                        r_state    <= LONG;
                        long_pulse <= 1'b1;
                        long_held  <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                GAP: begin
                    // A re-press on the expiry sample still counts as a double click.
                    if (w_rise) begin
                        r_state      <= PRESS2;
                        double_pulse <= 1'b1;
                    end else if (r_cnt >= GAP_LAST) begin
                        r_state     <= IDLE;
                        r_cnt       <= '0;
                        click_pulse <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                PRESS2: begin
                    if (w_fall) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                    end
                end
                LONG: begin
                    if (w_fall) begin
                        r_state   <= IDLE;
                        r_cnt     <= '0;
                        long_held <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_cnt     <= '0;
                    long_held <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_press_classifier.sv
// Scoreboard bench for press_classifier: a run-length reference model predicts the
// registered outputs per sample, and a negedge monitor compares them.
module tb_press_classifier;

    localparam int unsigned LP = 8;
    localparam int unsigned GP = 4;

    typedef struct {
        int       cyc;
        logic [4:0] outs;  // {click, double, long, held, busy}
    } rec_t;

    logic clk;
    logic rst;
    logic btn_level;
    logic click_pulse;
    logic double_pulse;
    logic long_pulse;
    logic long_held;
    logic busy;

    press_classifier #(
        .LONG_PRESS_TIME(LP),
        .DOUBLE_GAP_TIME(GP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_level   (btn_level),
        .click_pulse (click_pulse),
        .double_pulse(double_pulse),
        .long_pulse  (long_pulse),
        .long_held   (long_held),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;
    rec_t sb[$];

    // Reference model: count presses in the sequence and lengths of the current runs.
    logic m_prev;
    int   m_presses;
    int   m_hi_run;
    int   m_lo_run;
    bit   m_long;

    function automatic logic [4:0] dut_outs();
        return {click_pulse, double_pulse, long_pulse, long_held, busy};
    endfunction

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got {click,double,long,held,busy}=%b expected %b",
                     name, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        m_prev    = 1'b0;
        m_presses = 0;
        m_hi_run  = 0;
        m_lo_run  = 0;
        m_long    = 1'b0;
    endtask

    task automatic model_sample(input logic lvl, output logic [4:0] outs);
        bit ev_click, ev_double, ev_long;
        ev_click  = 0;
        ev_double = 0;
        ev_long   = 0;
        if (lvl && !m_prev) begin
            if (m_presses == 0) begin
                m_presses = 1;
                m_hi_run  = 1;
                m_lo_run  = 0;
            end else if (m_presses == 1 && m_lo_run > 0) begin
                ev_double = 1;
                m_presses = 2;
            end
        end else if (lvl && m_prev) begin
            if (m_presses == 1 && m_lo_run == 0 && !m_long) begin
                m_hi_run++;
                if (m_hi_run == LP) begin
                    ev_long = 1;
                    m_long  = 1;
                end
            end
        end else if (!lvl && m_prev) begin
            if (m_long || m_presses == 2) begin
                m_presses = 0;
                m_long    = 0;
            end else if (m_presses == 1) begin
                m_lo_run = 1;
            end
        end else begin
            if (m_presses == 1 && m_lo_run > 0) begin
                m_lo_run++;
                if (m_lo_run == GP) begin
                    ev_click  = 1;
                    m_presses = 0;
                    m_lo_run  = 0;
                end
            end
        end
        m_prev = lvl;
        outs = {ev_click, ev_double, ev_long, m_long, (m_presses > 0) || m_long};
    endtask

    task automatic step(input logic lvl);
        rec_t r;
        btn_level = lvl;
        model_sample(lvl, r.outs);
        r.cyc = cyc + 1;
        sb.push_back(r);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic lvl, input int n);
        for (int i = 0; i < n; i++) step(lvl);
    endtask

    // Async reset between edges: outputs must clear at once, pending predictions are void.
    task automatic async_reset(input logic lvl);
        #1;
        rst = 1'b1;
        btn_level = lvl;
        #1;
        chk("async_reset", dut_outs(), 5'b0);
        sb.delete();
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                rec_t s;
                s = sb.pop_front();
                chk("stale_prediction", 5'b0, 5'b11111);
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                rec_t e;
                e = sb.pop_front();
                chk("outputs", dut_outs(), e.outs);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        btn_level = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", dut_outs(), 5'b0);
        rst = 1'b0;

        // single click
        run(1, 3); run(0, 6);
        // double click
        run(1, 3); run(0, 2); run(1, 3); run(0, 6);
        // long press
        run(1, 12); run(0, 6);
        // gap boundary: expiry, then re-press on the expiry sample
        run(1, 3); run(0, 4); run(0, 2);
        run(1, 3); run(0, 3); run(1, 3); run(0, 6);
        // reset in PRESS1 at cnt=5, level kept high afterwards
        run(1, 5);
        async_reset(1'b1);
        run(1, 12); run(0, 6);
        // one sample short of long
        run(1, 7); run(0, 6);
        // back-to-back: re-press right after click expiry
        run(1, 2); run(0, 4); run(1, 2); run(0, 6);

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 14) == 0) async_reset(1'($urandom_range(0, 1)));
            run(1'(k % 2 == 0), int'($urandom_range(1, 12)));
        end

        run(0, 8);
        @(negedge clk);
        #1;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d predictions left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
